intr_ctrl: RTL and testbench

Interrupt controller that drives the interrupt side of the CPU's return-address stack. It synchronises and latches external interrupt requests and picks the highest-priority enabled one at an instruction boundary. It then issues the stack push and vector load on entry. On return it issues the stack pop with `s_intr` asserted, so the stack hands back the exact interrupted PC. It sits beside the control unit; `int_push`/`int_pop` are ORed with the CPU's call/return push/pop before reaching the stack.

---
 rtl/intr_pkg.sv | 16 +
 rtl/irq_sync.sv | 30 +++
 rtl/intr_ctrl.sv | 156 +++++++++++++++
 tb/tb_intr_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding and
// default sizing of the request lines, PC width and vector base.
package intr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_SERVICE = 2'd2,
        ST_EXIT    = 2'd3
    } intr_state_t;

    localparam int                N_IRQ_DEF    = 4;
    localparam int                AW_DEF       = 10;
    localparam logic [AW_DEF-1:0] VEC_BASE_DEF = 10'd1008;

endpackage

// File: rtl/irq_sync.sv
// Per-line two-flop synchroniser followed by a rising-edge detector.
// o_rise is high for one cycle per synchronised low-to-high transition.
module irq_sync #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_irq,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;
    logic [W-1:0] r_prev;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_irq;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller driving the interrupt side of the return-address stack:
// latches requests, selects a winner at an instruction boundary, sequences entry/exit.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no ISR active; entry taken on boundary with an eligible req
//   ENTER   | one cycle: push current PC, load vector, stall the CPU
//   SERVICE | ISR running; waits for reti
//   EXIT    | one cycle: pop with return correction, reload PC, restore ie
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int          N_IRQ    = N_IRQ_DEF,
    parameter int          AW       = AW_DEF,
    parameter logic [AW-1:0] VEC_BASE = AW'(VEC_BASE_DEF),
    localparam int         IW       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_din,
    input  logic             ei,
    input  logic             di,
    input  logic             boundary,
    input  logic             reti,
    output logic             int_push,
    output logic             int_pop,
    output logic             s_intr,
    output logic             vec_load,
    output logic             ret_load,
    output logic [AW-1:0]    vector,
    output logic             stall,
    output logic [N_IRQ-1:0] pending,
    output logic             ie,
    output logic             in_service,
    output logic [IW-1:0]    isr_id
);

    // Lowest set index wins; index 0 is the highest priority.
    function automatic logic [IW-1:0] prio_enc(input logic [N_IRQ-1:0] req);
        logic [IW-1:0] id;
        id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = IW'(i);
            end
        end
        return id;
    endfunction

    intr_state_t      r_state;
    intr_state_t      w_state_nxt;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_mask;
    logic             r_ie;
    logic [IW-1:0]    r_isr_id;
    logic             r_enter;
    logic             r_exit;
    logic             r_stall;
    logic             r_svc;
    logic [AW-1:0]    r_vector;

    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_elig;
    logic [IW-1:0]    w_winner;
    logic             w_take;
    logic [N_IRQ-1:0] w_clr;

    irq_sync #(
        .W (N_IRQ)
    ) u_irq_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_irq   (irq),
        .o_rise  (w_rise)
    );

    assign w_elig   = r_pending & r_mask & {N_IRQ{r_ie}};
    assign w_winner = prio_enc(w_elig);
    assign w_take   = (r_state == ST_IDLE) && boundary && (|w_elig);
    assign w_clr    = w_take ? (N_IRQ'(1) << w_winner) : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_take) w_state_nxt = ST_ENTER;
            ST_ENTER:   w_state_nxt = ST_SERVICE;
            ST_SERVICE: if (reti) w_state_nxt = ST_EXIT;
            ST_EXIT:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Pulse outputs come straight from flops loaded with the next-state decode,
    // so they line up with the state register and cannot glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_enter  <= 1'b0;
            r_exit   <= 1'b0;
            r_stall  <= 1'b0;
            r_svc    <= 1'b0;
            r_vector <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_enter  <= (w_state_nxt == ST_ENTER);
            r_exit   <= (w_state_nxt == ST_EXIT);
            r_stall  <= (w_state_nxt == ST_ENTER) || (w_state_nxt == ST_EXIT);
            r_svc    <= (w_state_nxt == ST_SERVICE);
            r_vector <= (w_state_nxt == ST_ENTER) ? (VEC_BASE + AW'(w_winner)) : '0;
        end
    end

    // A new edge on the bit being cleared re-latches it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_mask    <= '1;
            r_isr_id  <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (mask_we) begin
                r_mask <= mask_din;
            end
            if (w_take) begin
                r_isr_id <= w_winner;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ie <= 1'b0;
        end else if (r_state == ST_EXIT) begin
            r_ie <= 1'b1;
        end else if (w_take || di) begin
            r_ie <= 1'b0;
        end else if (ei) begin
            r_ie <= 1'b1;
        end
    end

    assign int_push   = r_enter;
    assign vec_load   = r_enter;
    assign int_pop    = r_exit;
    assign s_intr     = r_exit;
    assign ret_load   = r_exit;
    assign stall      = r_stall;
    assign in_service = r_svc;
    assign vector     = r_vector;
    assign pending    = r_pending;
    assign ie         = r_ie;
    assign isr_id     = r_isr_id;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: a behavioural model checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_din;
    logic       ei;
    logic       di;
    logic       boundary;
    logic       reti;
    logic       int_push;
    logic       int_pop;
    logic       s_intr;
    logic       vec_load;
    logic       ret_load;
    logic [9:0] vector;
    logic       stall;
    logic [3:0] pending;
    logic       ie;
    logic       in_service;
    logic [1:0] isr_id;

    int n_checks = 0;
    int n_errors = 0;

    intr_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_din   (mask_din),
        .ei         (ei),
        .di         (di),
        .boundary   (boundary),
        .reti       (reti),
        .int_push   (int_push),
        .int_pop    (int_pop),
        .s_intr     (s_intr),
        .vec_load   (vec_load),
        .ret_load   (ret_load),
        .vector     (vector),
        .stall      (stall),
        .pending    (pending),
        .ie         (ie),
        .in_service (in_service),
        .isr_id     (isr_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE    = 0;
    localparam int M_ENTER   = 1;
    localparam int M_SERVICE = 2;
    localparam int M_EXIT    = 3;

    int         m_mode = M_IDLE;
    logic [3:0] m_pend = 4'h0;
    logic [3:0] m_mask = 4'hF;
    logic       m_ie   = 1'b0;
    int         m_id   = 0;
    logic [3:0] hist[$];
    logic [3:0] m_arr;
    logic [3:0] m_elig;
    int         m_win;
    bit         m_take;

    // A request arrives at edge k when irq sampled at edge k-2 is high and
    // at edge k-3 was low (two synchroniser edges plus the detect edge).
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = M_IDLE;
            m_pend = 4'h0;
            m_mask = 4'hF;
            m_ie   = 1'b0;
            m_id   = 0;
            hist   = '{4'h0, 4'h0, 4'h0, 4'h0};
        end else begin
            hist.push_front(irq);
            m_arr = hist[2] & ~hist[3];
            void'(hist.pop_back());
            m_elig = m_pend & m_mask & {4{m_ie}};
            m_take = (m_mode == M_IDLE) && boundary && (m_elig != 4'h0);
            m_win  = -1;
            for (int i = 0; i < 4; i++) begin
                if (m_win < 0 && m_elig[i]) m_win = i;
            end
            if (m_mode == M_EXIT)  m_ie = 1'b1;
            else if (m_take)       m_ie = 1'b0;
            else if (di)           m_ie = 1'b0;
            else if (ei)           m_ie = 1'b1;
            if (m_take) begin
                m_id = m_win;
                m_pend[m_win] = 1'b0;
            end
            m_pend = m_pend | m_arr;
            if (mask_we) m_mask = mask_din;
            case (m_mode)
                M_IDLE:    m_mode = m_take ? M_ENTER : M_IDLE;
                M_ENTER:   m_mode = M_SERVICE;
                M_SERVICE: m_mode = reti ? M_EXIT : M_SERVICE;
                default:   m_mode = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("m_int_push",   int_push,   (m_mode == M_ENTER));
        chk("m_vec_load",   vec_load,   (m_mode == M_ENTER));
        chk("m_int_pop",    int_pop,    (m_mode == M_EXIT));
        chk("m_s_intr",     s_intr,     (m_mode == M_EXIT));
        chk("m_ret_load",   ret_load,   (m_mode == M_EXIT));
        chk("m_stall",      stall,      (m_mode == M_ENTER) || (m_mode == M_EXIT));
        chk("m_in_service", in_service, (m_mode == M_SERVICE));
        chk("m_vector",     vector,     (m_mode == M_ENTER) ? 1008 + m_id : 0);
        chk("m_pending",    pending,    m_pend);
        chk("m_ie",         ie,         m_ie);
        chk("m_isr_id",     isr_id,     m_id);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        irq = 4'h0; mask_we = 1'b0; mask_din = 4'h0;
        ei = 1'b0; di = 1'b0; boundary = 1'b0; reti = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_entry(input string name, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            tick();
            seen = vec_load;
        end
        chk(name, seen, 1);
    endtask

    // Called one step after the ENTER edge; leaves the DUT back in IDLE.
    task automatic exit_isr();
        tick();
        chk("svc_in_service", in_service, 1);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("exit_pop",   {int_pop, s_intr, ret_load, stall}, 4'b1111);
        chk("exit_push",  int_push, 0);
        tick();
        chk("exit_done",  {int_pop, s_intr, ret_load, stall, in_service}, 5'b0);
        chk("exit_ie",    ie, 1);
    endtask

    initial begin
        reset = 1'b1;
        irq = 4'h0; mask_we = 1'b0; mask_din = 4'h0;
        ei = 1'b0; di = 1'b0; boundary = 1'b0; reti = 1'b0;
        #1 reset = 1'b0;

        // Reset held with all requests high.
        irq = 4'hF;
        repeat (3) tick();
        chk("rst_flags",   {int_push, int_pop, s_intr, vec_load, ret_load, stall, ie, in_service}, 8'h00);
        chk("rst_vector",  vector, 0);
        chk("rst_pending", pending, 0);
        chk("rst_isr_id",  isr_id, 0);
        reset = 1'b1; ei = 1'b1; boundary = 1'b1;
        tick();
        ei = 1'b0;
        wait_entry("t1_entry_seen", 10);
        chk("t1_vector",  vector, 1008);
        chk("t1_pending", pending, 4'b1110);
        chk("t1_ie",      ie, 0);
        boundary = 1'b0;
        exit_isr();

        // Priority between two simultaneous requests, back-to-back entries.
        do_reset();
        ei = 1'b1;
        tick();
        ei = 1'b0;
        irq = 4'b0110;
        repeat (2) tick();
        chk("t2_latency_early", pending, 0);
        tick();
        chk("t2_pending", pending, 4'b0110);
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        chk("t2_push",       {int_push, vec_load, stall}, 3'b111);
        chk("t2_vector",     vector, 1009);
        chk("t2_pending_cl", pending, 4'b0100);
        chk("t2_isr_id",     isr_id, 1);
        exit_isr();
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        chk("t2_second_vec", vector, 1010);
        irq = 4'h0;
        exit_isr();

        // Masking holds a request pending; unmasking lets it in; di blocks entry.
        do_reset();
        ei = 1'b1; mask_we = 1'b1; mask_din = 4'b1110;
        tick();
        ei = 1'b0; mask_we = 1'b0;
        irq = 4'b0001; boundary = 1'b1;
        tick();
        irq = 4'h0;
        repeat (5) tick();
        chk("t3_masked_pend", pending, 4'b0001);
        chk("t3_masked_idle", {vec_load, in_service}, 2'b00);
        mask_we = 1'b1; mask_din = 4'hF;
        tick();
        mask_we = 1'b0;
        wait_entry("t3_unmask_entry", 4);
        chk("t3_vector", vector, 1008);
        boundary = 1'b0;
        exit_isr();
        irq = 4'b0010;
        tick();
        irq = 4'h0;
        repeat (3) tick();
        chk("t3_pend1", pending, 4'b0010);
        di = 1'b1;
        tick();
        di = 1'b0;
        chk("t3_di_ie", ie, 0);
        boundary = 1'b1;
        repeat (4) tick();
        chk("t3_di_noentry", {vec_load, in_service}, 2'b00);
        chk("t3_di_pend",    pending, 4'b0010);
        boundary = 1'b0;

        // Two edges while pending merge into one entry.
        do_reset();
        irq = 4'b1000; repeat (2) tick();
        irq = 4'h0;    repeat (2) tick();
        irq = 4'b1000; repeat (2) tick();
        irq = 4'h0;    repeat (3) tick();
        chk("t5_merged_pend", pending, 4'b1000);
        ei = 1'b1; boundary = 1'b1;
        tick();
        ei = 1'b0;
        wait_entry("t5_entry_seen", 4);
        boundary = 1'b0;
        chk("t5_vector", vector, 1011);
        chk("t5_cleared", pending, 0);
        exit_isr();
        boundary = 1'b1;
        repeat (4) tick();
        chk("t5_single_entry", {vec_load, in_service}, 2'b00);
        boundary = 1'b0;

        // An edge arriving on the very edge that clears pending[3] re-latches it.
        irq = 4'b1000; repeat (2) tick();
        irq = 4'h0;    repeat (3) tick();
        chk("t5_pend_again", pending, 4'b1000);
        irq = 4'b1000;
        repeat (2) tick();
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        irq = 4'h0;
        chk("t5_relatch_entry", vec_load, 1);
        chk("t5_relatch_pend",  pending, 4'b1000);
        exit_isr();
        boundary = 1'b1;
        wait_entry("t5_relatch_second", 4);
        boundary = 1'b0;
        chk("t5_second_vec", vector, 1011);
        exit_isr();

        // Reset while in SERVICE: straight back to IDLE, no pop.
        do_reset();
        ei = 1'b1; irq = 4'b0100;
        tick();
        ei = 1'b0; irq = 4'h0; boundary = 1'b1;
        wait_entry("t6_entry_seen", 6);
        boundary = 1'b0;
        chk("t6_vector", vector, 1010);
        tick();
        chk("t6_in_service", in_service, 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_flags", {in_service, int_pop, s_intr, ret_load, stall}, 5'b0);
        chk("t6_rst_isr_id", isr_id, 0);
        repeat (2) tick();
        reset = 1'b1;
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("t6_reti_ignored", {int_pop, ret_load, in_service, stall}, 4'b0);
        tick();
        chk("t6_still_idle", {int_pop, in_service}, 2'b00);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
